// File: rtl/exec_pkg.sv
// Shared types and constants for the multi-cycle execute stage.
package exec_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpSll = 3'b101,
    OpSrl = 3'b110,
    OpMul = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StWb
  } state_t;

  // EXEC cycle count; shifts by zero still take one cycle.
  function automatic logic [3:0] exec_steps(op_t op, logic [2:0] shamt, logic [3:0] mul_steps);
    logic [3:0] n;
    n = 4'd1;
    if (op == OpSll || op == OpSrl) begin
      n = (shamt == 3'd0) ? 4'd1 : {1'b0, shamt};
    end else if (op == OpMul) begin
      n = mul_steps;
    end
    return n;
  endfunction

endpackage

// File: rtl/exec_mul.sv
// Iterative 8x8 shift-add multiplier: load handles bit 0, each step one more multiplier bit.
module exec_mul
  import exec_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product
);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    if (load) begin
      mcand_d  = {{WIDTH{1'b0}}, a} << 1;
      mplier_d = b >> 1;
      prod_d   = b[0] ? {{WIDTH{1'b0}}, a} : '0;
    end else if (step) begin
      prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  assign product = prod_q;

endmodule

// File: rtl/exec_unit.sv
// Multi-cycle execute stage with start/busy/done handshake and register-file write-back.
// Define EXEC_MUL_EN to build the iterative multiplier; otherwise MUL is a no-write op.
module exec_unit
  import exec_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [SEL_W-1:0] dest,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             wr_en,
  output logic [SEL_W-1:0] wr_sel,
  output logic             zero,
  output logic             carry
);

`ifdef EXEC_MUL_EN
  localparam logic [3:0] MulSteps = 4'd8;
`else
  localparam logic [3:0] MulSteps = 4'd1;
`endif

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [SEL_W-1:0] dest_q, dest_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SEL_W-1:0] wr_sel_q, wr_sel_d;
  logic             busy_q, busy_d, done_q, done_d, wr_en_q, wr_en_d;
  logic             zero_q, zero_d, carry_q, carry_d;
  logic [WIDTH-1:0] fin;
  logic             fin_c;
  logic             accept;

  assign accept = (state_q == StIdle) && start;

`ifdef EXEC_MUL_EN
  logic [2*WIDTH-1:0] mul_product;

  exec_mul u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept && (op_t'(op) == OpMul)),
    .step    ((state_q == StExec) && (op_q == OpMul) && (cnt_q > 4'd1)),
    .a       (dataA),
    .b       (dataB),
    .product (mul_product)
  );
`endif

  // Value this EXEC cycle produces; for shifts it is also the next working value.
  always_comb begin
    fin   = '0;
    fin_c = 1'b0;
    unique case (op_q)
      OpAdd: {fin_c, fin} = {1'b0, work_q} + {1'b0, b_q};
      OpSub: begin
        fin   = work_q - b_q;
        fin_c = work_q < b_q;
      end
      OpAnd: fin = work_q & b_q;
      OpOr:  fin = work_q | b_q;
      OpXor: fin = work_q ^ b_q;
      OpSll: begin
        if (b_q[2:0] == 3'd0) fin = work_q;
        else                  {fin_c, fin} = {work_q, 1'b0};
      end
      OpSrl: begin
        if (b_q[2:0] == 3'd0) fin = work_q;
        else                  {fin, fin_c} = {1'b0, work_q};
      end
      OpMul: begin
`ifdef EXEC_MUL_EN
        fin   = mul_product[WIDTH-1:0];
        fin_c = |mul_product[2*WIDTH-1:WIDTH];
`else
        fin   = work_q;
`endif
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dest_d   = dest_q;
    work_d   = work_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    wr_sel_d = wr_sel_q;
    busy_d   = busy_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    wr_en_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = op_t'(op);
          dest_d  = dest;
          work_d  = dataA;
          b_d     = dataB;
          cnt_d   = exec_steps(op_t'(op), dataB[2:0], MulSteps);
          busy_d  = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        cnt_d  = cnt_q - 4'd1;
        work_d = fin;
        if (cnt_q == 4'd1) begin
          state_d  = StWb;
          done_d   = 1'b1;
          wr_sel_d = dest_q;
          if ((op_q != OpMul) || (MulSteps != 4'd1)) begin
            wr_en_d  = 1'b1;
            result_d = fin;
            carry_d  = fin_c;
            zero_d   = (fin == '0);
          end
        end
      end
      StWb: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      op_q     <= OpAdd;
      dest_q   <= '0;
      work_q   <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      wr_sel_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_en_q  <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dest_q   <= dest_d;
      work_q   <= work_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      wr_sel_q <= wr_sel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_en_q  <= wr_en_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign wr_en  = wr_en_q;
  assign wr_sel = wr_sel_q;
  assign zero   = zero_q;
  assign carry  = carry_q;

endmodule
